// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: credit, vend, coin-by-coin change dispense and display hold.
// Optional per-item stock tracking is compiled in with `define VEND_STOCK_EN.
module vend_ctrl_multi #(
    parameter int unsigned                 N_ITEMS     = 4,
    parameter int unsigned                 PRICE_W     = 7,
    parameter logic [N_ITEMS*PRICE_W-1:0]  PRICES      = {7'd30, 7'd24, 7'd15, 7'd5},
    parameter int unsigned                 COIN_HI     = 10,
    parameter int unsigned                 COIN_LO     = 5,
    parameter int unsigned                 MAX_CREDIT  = 100,
    parameter int unsigned                 PULSE_GAP   = 50_000_000,
    parameter int unsigned                 HOLD_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_sel,
    input  logic               key_coin_hi,
    input  logic               key_coin_lo,
    input  logic               key_cancel,
    input  logic               key_restock,
    output logic [3:0]         item_idx,
    output logic [PRICE_W-1:0] price_need,
    output logic [PRICE_W-1:0] credit,
    output logic [PRICE_W-1:0] change_out,
    output logic               vend_pulse,
    output logic               coin_hi_out,
    output logic               coin_lo_out,
    output logic               reject,
    output logic               busy,
    output logic [3:0]         led_value,
    output logic               sold_out
);

    localparam int unsigned CW     = PRICE_W + 1;
    localparam int unsigned GAP_W  = $clog2(PULSE_GAP);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_DISPENSE,
        S_HOLD
    } state_t;

    state_t              state, state_nxt;
    logic [PRICE_W-1:0]  rem;
    logic [GAP_W-1:0]    gap_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                refund, refund_nxt;
    logic [3:0]          item_nxt;

    logic                coin_key, coin_over, coin_take, coin_refuse;
    logic [CW-1:0]       coin_val, credit_sum;
    logic                refund_req, vend_due;
    logic [PRICE_W-1:0]  vend_change, coin_amt;
    logic                slot, rem_last, hold_done;

    // Wide sum so the ceiling comparison can never wrap.
    function automatic logic [CW-1:0] coin_sum(input logic [PRICE_W-1:0] cur,
                                               input logic [CW-1:0] val);
        return {1'b0, cur} + val;
    endfunction

    function automatic logic [3:0] led_code(input state_t s, input logic [3:0] idx,
                                            input logic rf);
        if (s == S_IDLE || s == S_CREDIT)
            return 4'd2 + idx;
        return rf ? 4'd15 : 4'd14;
    endfunction

    assign price_need = PRICES[item_idx*PRICE_W +: PRICE_W];

    always_comb begin
        coin_key    = key_coin_hi | key_coin_lo;
        coin_val    = key_coin_hi ? CW'(COIN_HI) : CW'(COIN_LO);
        credit_sum  = coin_sum(credit, coin_val);
        coin_over   = credit_sum > CW'(MAX_CREDIT);
        coin_take   = coin_key && !key_cancel && !sold_out && !coin_over;
        coin_refuse = coin_key && !key_cancel && (sold_out || coin_over);
        refund_req  = key_cancel || (key_sel && !coin_key);
        vend_due    = (state == S_CREDIT) && (credit >= price_need);
        vend_change = credit - price_need;
        slot        = (state == S_DISPENSE) && (gap_cnt == '0);
        coin_amt    = (rem >= PRICE_W'(COIN_HI)) ? PRICE_W'(COIN_HI) : PRICE_W'(COIN_LO);
        rem_last    = rem <= coin_amt;
        hold_done   = (state == S_HOLD) && (hold_cnt == '0);
    end

    always_comb begin
        item_nxt = item_idx;
        if (state == S_IDLE && key_sel && !key_cancel && !coin_key)
            item_nxt = (item_idx == 4'(N_ITEMS - 1)) ? 4'd0 : item_idx + 4'd1;
    end

    always_comb begin
        refund_nxt = refund;
        if (state == S_CREDIT && !vend_due && refund_req)
            refund_nxt = 1'b1;
        else if (hold_done)
            refund_nxt = 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (coin_take) state_nxt = S_CREDIT;
            S_CREDIT: begin
                if (vend_due)
                    state_nxt = S_VEND;
                else if (refund_req)
                    state_nxt = S_DISPENSE;
            end
            S_VEND:     state_nxt = (vend_change == '0) ? S_HOLD : S_DISPENSE;
            S_DISPENSE: if (slot && rem_last) state_nxt = S_HOLD;
            S_HOLD:     if (hold_done) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        vend_pulse  = (state == S_VEND);
        busy        = (state == S_VEND) || (state == S_DISPENSE) || (state == S_HOLD);
        coin_hi_out = slot && (rem >= PRICE_W'(COIN_HI));
        coin_lo_out = slot && (rem < PRICE_W'(COIN_HI)) && (rem != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            item_idx   <= 4'd0;
            credit     <= '0;
            change_out <= '0;
            rem        <= '0;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
            refund     <= 1'b0;
            reject     <= 1'b0;
            led_value  <= 4'd1;
        end else begin
            item_idx  <= item_nxt;
            refund    <= refund_nxt;
            reject    <= 1'b0;
            led_value <= led_code(state_nxt, item_nxt, refund_nxt);
            case (state)
                S_IDLE: begin
                    if (coin_take)
                        credit <= credit_sum[PRICE_W-1:0];
                    else if (coin_refuse)
                        reject <= 1'b1;
                end
                S_CREDIT: begin
                    if (!vend_due) begin
                        if (refund_req) begin
                            change_out <= credit;
                            rem        <= credit;
                            gap_cnt    <= '0;
                        end else if (coin_take) begin
                            credit <= credit_sum[PRICE_W-1:0];
                        end else if (coin_refuse) begin
                            reject <= 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    change_out <= vend_change;
                    rem        <= vend_change;
                    gap_cnt    <= '0;
                    hold_cnt   <= HOLD_W'(HOLD_CYCLES - 1);
                end
                S_DISPENSE: begin
                    if (slot) begin
                        rem      <= rem_last ? '0 : rem - coin_amt;
                        gap_cnt  <= GAP_W'(PULSE_GAP - 1);
                        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        credit     <= '0;
                        change_out <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VEND_STOCK_EN
    localparam int unsigned IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic [3:0] stock [N_ITEMS];
    logic [IDX_W-1:0] stock_idx;

    assign stock_idx = item_idx[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && key_restock)) begin
            for (int i = 0; i < N_ITEMS; i++)
                stock[i] <= 4'd9;
        end else if (state == S_VEND && stock[stock_idx] != 4'd0) begin
            stock[stock_idx] <= stock[stock_idx] - 4'd1;
        end
    end

    assign sold_out = (stock[stock_idx] == 4'd0);
`else
    logic unused_restock;
    assign unused_restock = key_restock;
    assign sold_out       = 1'b0;
`endif

endmodule
